// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//
// Sends one byte to a PS/2 device. The host holds the clock line low to
// inhibit the device, then releases it while pulling data low (start bit).
// The device then generates the clock. The host presents each frame bit
// after a falling edge and checks the device acknowledge on the 11th edge.
//
// Ports:
//   clk, resetn            system clock (rising edge); asynchronous active-low reset
//   tx_data[7:0]           command byte, sampled only on the accepting cycle
//   tx_valid / tx_ready    request handshake (see below)
//   ps2_clk_in, ps2_dat_in raw, asynchronous PS/2 line levels
//   ps2_clk_oe, ps2_dat_oe 1 = pull the line low, 0 = release (open drain)
//   done                   one-cycle pulse after an acknowledged transfer
//   err                    one-cycle pulse on negative acknowledge or timeout
//   busy                   high in every state except IDLE
//
// Handshake: a transfer is accepted on a rising clk edge where tx_valid and
// tx_ready are both high. tx_ready is high only in IDLE; tx_valid while busy
// is dropped, not queued. Every accepted transfer ends with exactly one
// done or one err pulse, never both.
//
// The FSM state is the enum signal "state", which checkers can bind to.

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       done,
    output logic       err,
    output logic       busy
);

    localparam int               INH_W    = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    // Timeout fires on the cycle after the counter shows TIMEOUT_CYCLES-1,
    // so err lands exactly TIMEOUT_CYCLES cycles after SHIFT entry.
    localparam logic [19:0]      TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t           state;
    logic [10:0]      frame;
    logic [3:0]       bitcnt;
    logic [INH_W-1:0] inh_cnt;
    logic [19:0]      to_cnt;
    logic             ack_bit;

    // Two-flop synchronizers plus one history flop on the clock line for
    // falling-edge detection. Idle PS/2 lines are high, so reset to 1.
    logic clk_s1, clk_s2, clk_s3;
    logic dat_s1, dat_s2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_in;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_dat_in;
            dat_s2 <= dat_s1;
        end
    end

    logic fall;
    logic timeout;

    assign fall    = clk_s3 & ~clk_s2;
    assign timeout = (to_cnt >= TO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            frame      <= '0;
            bitcnt     <= '0;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            ack_bit    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // Saturating transfer timer; cleared on SHIFT entry.
            if ((state == SHIFT || state == ACK || state == WAIT_IDLE) && (to_cnt != 20'hFFFFF))
                to_cnt <= to_cnt + 20'd1;

            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        // {stop, odd parity, data, start}
                        frame      <= {1'b1, ~^tx_data, tx_data, 1'b0};
                        bitcnt     <= '0;
                        inh_cnt    <= '0;
                        state      <= INHIBIT;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        ps2_dat_oe <= 1'b0;
                    end
                end

                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        state      <= SHIFT;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= ~frame[0];
                        to_cnt     <= '0;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end

                SHIFT: begin
                    if (timeout) begin
                        err        <= 1'b1;
                        state      <= IDLE;
                        tx_ready   <= 1'b1;
                        busy       <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                    end else if (fall) begin
                        if (bitcnt == 4'd10) begin
                            // 11th falling edge: the device drives the ack now.
                            state      <= ACK;
                            ack_bit    <= dat_s2;
                            ps2_dat_oe <= 1'b0;
                        end else begin
                            bitcnt     <= bitcnt + 4'd1;
                            ps2_dat_oe <= ~frame[bitcnt + 4'd1];
                        end
                    end
                end

                ACK: begin
                    if (timeout || ack_bit) begin
                        err      <= 1'b1;
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        state <= WAIT_IDLE;
                    end
                end

                WAIT_IDLE: begin
                    if (timeout) begin
                        err      <= 1'b1;
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else if (clk_s2 && dat_s2) begin
                        done     <= 1'b1;
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    tx_ready   <= 1'b1;
                    busy       <= 1'b0;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule
